prefetch_queue: RTL and testbench
=================================

# prefetch_queue

Instruction byte prefetch queue between the instruction memory and the fetch stage. Issues sequential word reads to memory, keeps up to DEPTH_BYTES of fetched instruction bytes in a little-endian byte FIFO, and presents the oldest MAX_INSTR_BYTES bytes with their PC so fetch can carve variable-length instructions (1..MAX_INSTR_BYTES bytes). A redirect flushes the queue and restarts prefetch at any byte address; a response already in flight for the old stream is discarded.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, memory word width; fixed at 32 (4 bytes/word)
- MAX_INSTR_BYTES, 8, bytes exposed to fetch per cycle
- DEPTH_BYTES, 16, queue capacity in bytes; power of two, >= MAX_INSTR_BYTES + 4
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- i_redirect_valid  in  1  flush and restart at i_redirect_pc
- i_redirect_pc  in  ADDRESS_WIDTH  new stream byte address (any alignment)
- o_mem_valid  out  1  read request valid
- o_mem_addr  out  ADDRESS_WIDTH  word-aligned read address (low 2 bits 0)
- i_mem_ready  in  1  memory accepts request this cycle
- i_mem_res_valid  in  1  read data valid (in order, one per accepted request)
- i_mem_data  in  DATA_WIDTH  read data, byte 0 = bits [7:0]
- o_bytes  out  8*MAX_INSTR_BYTES  oldest bytes; byte k at bits [8k+7:8k]; bytes >= o_count are X
- o_count  out  clog2(MAX_INSTR_BYTES)+1  valid bytes in o_bytes, min(occupancy, MAX_INSTR_BYTES)
- o_pc  out  ADDRESS_WIDTH  address of o_bytes byte 0
- i_consume_len  in  clog2(MAX_INSTR_BYTES)+1  bytes fetch pops this cycle (0 = none)

## Operation
- State machine: IDLE (no request outstanding), WAIT (one accepted request, response belongs to current stream), STALE (one accepted request, response to be dropped).
- At most one outstanding request. In IDLE, o_mem_valid=1 when DEPTH_BYTES - occupancy >= 4; o_mem_addr = fetch word pointer. Handshake o_mem_valid & i_mem_ready -> WAIT, pointer += 4. o_mem_valid held with stable address until accepted.
- WAIT + i_mem_res_valid: push 4 bytes, skipping the first `skip` bytes (skip = redirect pc[1:0] for the first word after redirect, else 0); -> IDLE.
- STALE + i_mem_res_valid: data dropped; -> IDLE.
- Pop: occupancy -= i_consume_len, o_pc += i_consume_len. i_consume_len > o_count is illegal (bench asserts; RTL behaviour undefined).
- Push and pop in same cycle both apply; occupancy next = occ + pushed - popped.
- Redirect (highest priority, overrides push/pop/request that cycle): occupancy := 0, o_pc := i_redirect_pc, word pointer := i_redirect_pc & ~3, skip := i_redirect_pc[1:0]. State: IDLE->IDLE, WAIT->STALE, STALE->STALE. Request being accepted in the redirect cycle (o_mem_valid & i_mem_ready) counts as in flight -> STALE.
- o_pc and pointers wrap modulo 2^ADDRESS_WIDTH; byte FIFO indices wrap modulo DEPTH_BYTES.

## Timing
- Reset (async assert): state IDLE, occupancy 0, o_count 0, o_mem_valid 0, o_mem_addr RESET_PC, o_pc RESET_PC, skip 0.
- o_mem_valid, o_mem_addr, o_bytes, o_count, o_pc are registered (no combinational path from any input).
- First request: o_mem_valid=1 on the first rising edge after reset deasserts (visible cycle 1).
- Response in cycle N -> bytes visible (o_count updated) in cycle N+1; next request earliest cycle N+1.
- Pop in cycle N -> o_bytes/o_pc/o_count updated cycle N+1; space freed usable for request decision in N+1.
- Redirect in cycle N -> o_count=0, o_pc=new pc in N+1; new request o_mem_valid in N+1 if IDLE, else after stale response drains.
- Full: no request when free < 4; o_mem_valid deasserts only when not already asserted-and-pending (a pending request is never withdrawn except by redirect).

## Test plan
- Reset, memory always ready, 1-cycle response, words 0x03020100, 0x07060504 -> requests at 0x0, 0x4; after both: o_count=8, o_bytes=0x0706050403020100, o_pc=0.
- No consumption, continuous responses, DEPTH_BYTES=16 -> exactly 4 requests (0x0..0xC), o_mem_valid stays 0, occupancy 16, o_count=8.
- Consume 3 then 5 while filling -> o_pc 0x3 then 0x8, o_bytes byte0 = 0x03 then 0x08; push+pop same cycle gives correct occupancy.
- Redirect to 0x102 from IDLE, data 0xDDCCBBAA at 0x100 -> request addr 0x100, o_pc=0x102, o_count=2, o_bytes[15:0]=0xDDCC.
- Redirect to 0x40 while request to 0x8 outstanding (response delayed 3 cycles) -> response dropped, no new request until it returns, then request 0x40; o_count stays 0 until 0x40 data.
- Assert reset mid-WAIT with pending response -> all outputs at reset values immediately; post-release request to RESET_PC, late old response ignored by bench-memory reset.

Source files
------------

// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential word prefetch into a byte FIFO exposing the oldest instruction bytes
module prefetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_INSTR_BYTES = 8,
    parameter int DEPTH_BYTES = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]             i_redirect_pc,
    output logic                                 o_mem_valid,
    output logic [ADDRESS_WIDTH-1:0]             o_mem_addr,
    input  logic                                 i_mem_ready,
    input  logic                                 i_mem_res_valid,
    input  logic [DATA_WIDTH-1:0]                i_mem_data,
    output logic [8*MAX_INSTR_BYTES-1:0]         o_bytes,
    output logic [$clog2(MAX_INSTR_BYTES):0]     o_count,
    output logic [ADDRESS_WIDTH-1:0]             o_pc,
    input  logic [$clog2(MAX_INSTR_BYTES):0]     i_consume_len
);
    localparam int CW = $clog2(MAX_INSTR_BYTES) + 1;
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int OW = IW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, STALE} state_t;

    state_t state, state_next;
    logic [7:0] fifo [DEPTH_BYTES];
    logic [IW-1:0] rd_ptr, rd_ptr_next;
    logic [IW-1:0] widx [4];
    logic [OW-1:0] occ, occ_next, push_len, pop_len;
    logic [ADDRESS_WIDTH-1:0] fetch_ptr, fetch_ptr_next, pc, pc_next;
    logic [1:0] skip, skip_next;
    logic mem_valid, mem_valid_next, handshake, push;

    assign handshake = mem_valid && i_mem_ready;
    assign push = (state == WAIT) && i_mem_res_valid && !i_redirect_valid;
    assign push_len = push ? OW'(4) - OW'(skip) : '0;
    assign pop_len = i_redirect_valid ? '0 : OW'(i_consume_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request accepted in the redirect cycle is already in flight, so its data must be dropped
    always_comb begin
        state_next = state;
        if (i_redirect_valid)
            state_next = (state != IDLE || handshake) ? STALE : IDLE;
        else if (state == IDLE)
            state_next = handshake ? WAIT : IDLE;
        else
            state_next = i_mem_res_valid ? IDLE : state;
    end

    always_comb begin
        mem_valid_next = (state_next == IDLE) && ((OW'(DEPTH_BYTES) - occ_next) >= OW'(4));
    end

    always_comb begin
        occ_next = i_redirect_valid ? '0 : occ + push_len - pop_len;
        rd_ptr_next = rd_ptr + IW'(pop_len);
        pc_next = i_redirect_valid ? i_redirect_pc : pc + ADDRESS_WIDTH'(i_consume_len);
        fetch_ptr_next = i_redirect_valid ? {i_redirect_pc[ADDRESS_WIDTH-1:2], 2'b00} :
                         handshake ? fetch_ptr + ADDRESS_WIDTH'(4) : fetch_ptr;
        skip_next = i_redirect_valid ? i_redirect_pc[1:0] : push ? 2'b00 : skip;
        for (int k = 0; k < 4; k++)
            widx[k] = rd_ptr + IW'(occ) + IW'(k) - IW'(skip);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            occ <= '0;
            fetch_ptr <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
            pc <= RESET_PC;
            skip <= 2'b00;
            mem_valid <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_next;
            occ <= occ_next;
            fetch_ptr <= fetch_ptr_next;
            pc <= pc_next;
            skip <= skip_next;
            mem_valid <= mem_valid_next;
        end
    end

    // Storage needs no reset: occupancy alone says which bytes are meaningful
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (push && 2'(k) >= skip) fifo[widx[k]] <= i_mem_data[8*k +: 8];
    end

    always_comb begin
        o_bytes = '0;
        for (int k = 0; k < MAX_INSTR_BYTES; k++)
            o_bytes[8*k +: 8] = fifo[rd_ptr + IW'(k)];
        o_count = (occ > OW'(MAX_INSTR_BYTES)) ? CW'(MAX_INSTR_BYTES) : CW'(occ);
        o_mem_valid = mem_valid;
        o_mem_addr = fetch_ptr;
        o_pc = pc;
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed vectors plus redirect/reset sequences against a bench memory model
module tb_prefetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic o_mem_valid;
    logic [31:0] o_mem_addr;
    logic i_mem_ready = 1'b1;
    logic i_mem_res_valid = 1'b0;
    logic [31:0] i_mem_data = '0;
    logic [63:0] o_bytes;
    logic [3:0] o_count;
    logic [31:0] o_pc;
    logic [3:0] i_consume_len = '0;

    prefetch_queue #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_INSTR_BYTES(8), .DEPTH_BYTES(16), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .i_mem_ready(i_mem_ready),
        .i_mem_res_valid(i_mem_res_valid), .i_mem_data(i_mem_data),
        .o_bytes(o_bytes), .o_count(o_count), .o_pc(o_pc), .i_consume_len(i_consume_len)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic pending = 1'b0;
    logic [31:0] pend_addr = '0;
    int cnt = 0;
    int lat = 0;
    logic [31:0] req_log [$];

    typedef struct {
        logic [3:0] consume;
        logic exp_valid;
        logic [31:0] exp_addr;
        logic [3:0] exp_count;
        logic [31:0] exp_pc;
        logic [7:0] exp_b0;
    } vec_t;
    vec_t vecs [16];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return (a == 32'h100) ? 32'hDDCCBBAA : {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: memory accepts/answers in order with `lat` extra cycles of delay
    task automatic tick();
        logic hs, resp;
        logic [31:0] a;
        assert (i_consume_len <= o_count) else $error("illegal consume %0d > %0d", i_consume_len, o_count);
        hs = o_mem_valid && i_mem_ready;
        resp = i_mem_res_valid;
        a = o_mem_addr;
        @(posedge clk);
        #1;
        i_redirect_valid = 1'b0;
        i_consume_len = '0;
        if (resp) pending = 1'b0;
        if (hs) begin
            pending = 1'b1;
            pend_addr = a;
            cnt = lat;
            req_log.push_back(a);
        end else if (pending && cnt > 0) begin
            cnt--;
        end
        i_mem_res_valid = pending && cnt == 0;
        i_mem_data = pending ? word_at(pend_addr) : '0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect_valid = 1'b1;
        i_redirect_pc = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'd0, 1'b1, 32'h00, 4'd0, 32'h00, 8'h00};
        vecs[1]  = '{4'd0, 1'b0, 32'h00, 4'd0, 32'h00, 8'h00};
        vecs[2]  = '{4'd0, 1'b1, 32'h04, 4'd4, 32'h00, 8'h00};
        vecs[3]  = '{4'd0, 1'b0, 32'h00, 4'd4, 32'h00, 8'h00};
        vecs[4]  = '{4'd0, 1'b1, 32'h08, 4'd8, 32'h00, 8'h00};
        vecs[5]  = '{4'd0, 1'b0, 32'h00, 4'd8, 32'h00, 8'h00};
        vecs[6]  = '{4'd0, 1'b1, 32'h0C, 4'd8, 32'h00, 8'h00};
        vecs[7]  = '{4'd0, 1'b0, 32'h00, 4'd8, 32'h00, 8'h00};
        vecs[8]  = '{4'd0, 1'b0, 32'h00, 4'd8, 32'h00, 8'h00};
        vecs[9]  = '{4'd0, 1'b0, 32'h00, 4'd8, 32'h00, 8'h00};
        vecs[10] = '{4'd3, 1'b0, 32'h00, 4'd8, 32'h03, 8'h03};
        vecs[11] = '{4'd5, 1'b1, 32'h10, 4'd8, 32'h08, 8'h08};
        vecs[12] = '{4'd0, 1'b0, 32'h00, 4'd8, 32'h08, 8'h08};
        vecs[13] = '{4'd2, 1'b1, 32'h14, 4'd8, 32'h0A, 8'h0A};
        vecs[14] = '{4'd8, 1'b0, 32'h00, 4'd2, 32'h12, 8'h12};
        vecs[15] = '{4'd2, 1'b1, 32'h18, 4'd4, 32'h14, 8'h14};

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", o_mem_valid, 0);
        check("reset_addr", o_mem_addr, 32'h0);
        check("reset_count", o_count, 0);
        check("reset_pc", o_pc, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            i_consume_len = vecs[i].consume;
            tick();
            check($sformatf("vec%0d_valid", i), o_mem_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_addr", i), o_mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_count", i), o_count, vecs[i].exp_count);
            check($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
            if (vecs[i].exp_count != 0) check($sformatf("vec%0d_b0", i), o_bytes[7:0], vecs[i].exp_b0);
            if (i == 4) check("two_words_bytes", o_bytes, 64'h0706050403020100);
            if (i == 9) check("full_req_count", req_log.size(), 4);
        end
        check("req_log_size", req_log.size(), 6);
        for (int i = 0; i < 6 && i < req_log.size(); i++)
            check($sformatf("req%0d_addr", i), req_log[i], 32'(4 * i));

        // Redirect from IDLE to a misaligned pc
        i_mem_ready = 1'b0;
        redirect(32'h102);
        tick();
        check("rd_count", o_count, 0);
        check("rd_pc", o_pc, 32'h102);
        check("rd_valid", o_mem_valid, 1);
        check("rd_addr", o_mem_addr, 32'h100);
        i_mem_ready = 1'b1;
        tick();
        check("rd_wait_valid", o_mem_valid, 0);
        tick();
        check("rd_skip_count", o_count, 2);
        check("rd_skip_bytes", o_bytes[15:0], 16'hDDCC);
        check("rd_skip_pc", o_pc, 32'h102);
        check("rd_next_addr", o_mem_addr, 32'h104);
        check("rd_req_addr", req_log[req_log.size()-1], 32'h100);

        // Redirect while a slow response is outstanding: it must be dropped
        i_mem_ready = 1'b0;
        redirect(32'h8);
        tick();
        check("st_addr8", o_mem_addr, 32'h8);
        i_mem_ready = 1'b1;
        lat = 3;
        tick();
        redirect(32'h40);
        tick();
        check("st_pc", o_pc, 32'h40);
        check("st_count", o_count, 0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("st_hold%0d_valid", i), o_mem_valid, 0);
            tick();
            check($sformatf("st_hold%0d_count", i), o_count, 0);
        end
        check("st_hold_valid", o_mem_valid, 0);
        tick();
        check("st_drain_valid", o_mem_valid, 1);
        check("st_drain_addr", o_mem_addr, 32'h40);
        check("st_drain_count", o_count, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("st_wait%0d_count", i), o_count, 0);
        end
        tick();
        check("st_new_count", o_count, 4);
        check("st_new_b0", o_bytes[7:0], 8'h40);
        check("st_new_pc", o_pc, 32'h40);

        // Reset asserted with a response still pending
        lat = 2;
        tick();
        check("rs_wait_valid", o_mem_valid, 0);
        #2;
        reset = 1'b0;
        pending = 1'b0;
        i_mem_res_valid = 1'b0;
        #1;
        check("rs_valid", o_mem_valid, 0);
        check("rs_addr", o_mem_addr, 32'h0);
        check("rs_count", o_count, 0);
        check("rs_pc", o_pc, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        lat = 0;
        tick();
        check("rs_req_valid", o_mem_valid, 1);
        check("rs_req_addr", o_mem_addr, 32'h0);
        tick();
        tick();
        check("rs_fill_count", o_count, 4);
        check("rs_fill_bytes", o_bytes[31:0], 32'h03020100);
        check("rs_fill_pc", o_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
